// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// The optional perf counters in pipe_ctrl_unit are enabled by defining SCU_PERF_EN.
package pipe_ctrl_unit_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StFlush = 1'b1
  } scu_state_e;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int unsigned DefNstage   = 6;
  localparam int unsigned DefMcStage  = 3;
  localparam int unsigned DefLenW     = 6;
  localparam int unsigned DefFlushCyc = 1;
  localparam int unsigned DefCntW     = 32;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Request/response bundle between the pipeline and the stall/flush controller.
interface pipe_ctrl_unit_if #(
  parameter int unsigned NSTAGE = 6,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned CNT_W  = 32
);
  logic [NSTAGE-1:0] stall_req;
  logic              mc_start;
  logic [LEN_W-1:0]  mc_len;
  logic              flush_req;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic              mc_busy;
  logic [CNT_W-1:0]  perf_stall_cyc;
  logic [CNT_W-1:0]  perf_flush_cnt;

  modport master (
    output stall_req, mc_start, mc_len, flush_req,
    input  stall, flush, mc_busy, perf_stall_cyc, perf_flush_cnt
  );

  modport slave (
    input  stall_req, mc_start, mc_len, flush_req,
    output stall, flush, mc_busy, perf_stall_cyc, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_unit_stall_timer.sv
// Countdown for fixed-latency multi-cycle ops; busy while the count is non-zero.
module pipe_ctrl_unit_stall_timer #(
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy
);
  logic [LEN_W-1:0] cnt_q, cnt_d;

  assign busy = (cnt_q != '0);

  // The start cycle itself is one stall cycle, so load len-1.
  always_comb begin
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start && !busy && (len != '0)) begin
      cnt_d = len - LEN_W'(1);
    end else if (busy) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush controller: prefix stall mask, multi-cycle timer, sequenced flush.
// Define SCU_PERF_EN to build the saturating stall-cycle and flush-event counters.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int unsigned NSTAGE    = DefNstage,
  parameter int unsigned MC_STAGE  = DefMcStage,
  parameter int unsigned LEN_W     = DefLenW,
  parameter int unsigned FLUSH_CYC = DefFlushCyc,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic          cpu_clk_50M,
  input  logic          cpu_rst_n,
  pipe_ctrl_unit_if.slave bus
);
  localparam int unsigned FcntW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FcntW-1:0] FcntReload = FcntW'(FLUSH_CYC - 1);

  scu_state_e        state_q, state_d;
  logic [FcntW-1:0]  fcnt_q, fcnt_d;
  logic              flush_q, flush_d;
  logic              mc_busy;
  logic              tmr_req;
  logic [NSTAGE-1:0] eff;
  logic [NSTAGE-1:0] stall_mask;
  logic              acc;

  pipe_ctrl_unit_stall_timer #(
    .LEN_W (LEN_W)
  ) u_stall_timer (
    .clk   (cpu_clk_50M),
    .rst_n (cpu_rst_n),
    .start (bus.mc_start && (state_q == StIdle)),
    .len   (bus.mc_len),
    .abort ((state_q == StIdle) && bus.flush_req),
    .busy  (mc_busy)
  );

  assign tmr_req = (bus.mc_start && (bus.mc_len != '0) && !mc_busy) || mc_busy;
  assign eff     = bus.stall_req | (NSTAGE'(tmr_req) << MC_STAGE);

  // Highest requesting stage stalls itself and everything upstream of it.
  always_comb begin
    stall_mask = '0;
    acc        = 1'b0;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      acc           = acc | eff[i];
      stall_mask[i] = acc;
    end
    if (!cpu_rst_n || (state_q == StFlush)) begin
      stall_mask = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.flush_req) begin
          state_d = StFlush;
          fcnt_d  = FcntReload;
        end
      end
      StFlush: begin
        if (bus.flush_req) begin
          fcnt_d = FcntReload;
        end else if (fcnt_q != '0) begin
          fcnt_d = fcnt_q - FcntW'(1);
        end else begin
          state_d = StIdle;
        end
      end
    endcase
    flush_d = (state_d == StFlush);
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= StIdle;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flush_q <= flush_d;
    end
  end

  assign bus.stall   = stall_mask;
  assign bus.flush   = flush_q;
  assign bus.mc_busy = mc_busy;

`ifdef SCU_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_mask[0] && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + CNT_W'(1);
      end
      if ((state_q == StIdle) && (state_d == StFlush) && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.perf_stall_cyc = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`else
  assign bus.perf_stall_cyc = '0;
  assign bus.perf_flush_cnt = '0;
`endif
endmodule
